// File: rtl/serial_deserializer.sv
// MSB-first serial-to-parallel receiver with a one-entry Valid/Ready output buffer
// and a sticky overrun flag for words dropped under back-pressure.
`timescale 1ns/1ps
module serial_deserializer #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             SerialIn,
    input  logic             Start,
    input  logic             Ready,
    output logic [SIZE-1:0]  Q,
    output logic             Valid,
    output logic             Overrun,
    output logic [CNT_W-1:0] BitCount
);

    localparam int unsigned LAST_BIT = SIZE - 1;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    // Only SIZE-1 bits need storing: the final bit completes the word directly.
    logic [SIZE-2:0]  shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]  word_q, word_d;
    logic             ovr_q, ovr_d;
    buf_state_e       state_q, state_d;

    logic [SIZE-1:0]  next_word;
    logic             complete;

    // Shift path: Start wins over Enable, last bit completes and clears the word.
    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        complete  = 1'b0;
        next_word = {shift_q, SerialIn};
        if (Start) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (Enable) begin
            if (cnt_q == CNT_W'(LAST_BIT)) begin
                complete = 1'b1;
                shift_d  = '0;
                cnt_d    = '0;
            end else begin
                shift_d = next_word[SIZE-2:0];
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output buffer: a completion into a full, stalled buffer is dropped.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ovr_d   = ovr_q;
        if (Start) begin
            ovr_d = 1'b0;
        end
        unique case (state_q)
            EMPTY: begin
                if (complete) begin
                    word_d  = next_word;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    if (Ready) begin
                        word_d = next_word;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (Ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            ovr_q   <= 1'b0;
            state_q <= EMPTY;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            ovr_q   <= ovr_d;
            state_q <= state_d;
        end
    end

    assign Q        = word_q;
    assign Valid    = (state_q == FULL);
    assign Overrun  = ovr_q;
    assign BitCount = cnt_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: vector table, directed corner sequences, and
// random traffic checked against a bit-queue reference model.
`timescale 1ns/1ps
module tb_serial_deserializer;

    localparam int unsigned SIZE  = 16;
    localparam int unsigned CNT_W = 5;

    logic             Clock = 1'b0;
    logic             Reset, Enable, SerialIn, Start, Ready;
    logic [SIZE-1:0]  Q;
    logic             Valid, Overrun;
    logic [CNT_W-1:0] BitCount;

    serial_deserializer #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .SerialIn(SerialIn),
        .Start(Start), .Ready(Ready), .Q(Q), .Valid(Valid),
        .Overrun(Overrun), .BitCount(BitCount)
    );

    always #5 Clock = ~Clock;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: partial word kept as a list of received bits.
    int              m_bits[$];
    logic [SIZE-1:0] m_q;
    logic            m_valid;
    logic            m_ovr;

    typedef struct packed {
        logic       en;
        logic       si;
        logic       st;
        logic       rdy;
        logic [4:0] cnt;
        logic       valid;
        logic       ovr;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_q = '0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic si, input logic st, input logic rdy);
        logic [SIZE-1:0] w;
        bit done;
        done = 0;
        w = '0;
        if (st) begin
            m_bits.delete();
            m_ovr = 1'b0;
        end else if (en) begin
            m_bits.push_back(int'(si));
            if (m_bits.size() == SIZE) begin
                foreach (m_bits[i]) w = SIZE'((w << 1) | SIZE'(m_bits[i]));
                m_bits.delete();
                done = 1;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_q = w;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".Q"}, 32'(Q), 32'(m_q));
        chk({tag, ".Valid"}, 32'(Valid), 32'(m_valid));
        chk({tag, ".Overrun"}, 32'(Overrun), 32'(m_ovr));
        chk({tag, ".BitCount"}, 32'(BitCount), 32'(m_bits.size()));
    endtask

    task automatic step(input string tag, input logic en, input logic si, input logic st, input logic rdy);
        Enable = en; SerialIn = si; Start = st; Ready = rdy;
        @(posedge Clock);
        model_edge(en, si, st, rdy);
        #1;
        check_model(tag);
    endtask

    // Ready stays low except on the final bit, where rdy_last applies.
    task automatic send_word(input string tag, input logic [SIZE-1:0] w, input bit gaps, input logic rdy_last);
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (gaps) step(tag, 1'b0, 1'b1, 1'b0, 1'b0);
            step(tag, 1'b1, w[i], 1'b0, (i == 0) ? rdy_last : 1'b0);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #2;
        Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b0; SerialIn = 1'b0; Start = 1'b0; Ready = 1'b0;
        model_reset();

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};

        do_reset();
        chk("reset.Q", 32'(Q), 32'h0);
        chk("reset.Valid", 32'(Valid), 32'h0);
        chk("reset.Overrun", 32'(Overrun), 32'h0);
        chk("reset.BitCount", 32'(BitCount), 32'h0);

        foreach (tbl[i]) begin
            Enable = tbl[i].en; SerialIn = tbl[i].si; Start = tbl[i].st; Ready = tbl[i].rdy;
            @(posedge Clock);
            model_edge(tbl[i].en, tbl[i].si, tbl[i].st, tbl[i].rdy);
            #1;
            chk($sformatf("tbl%0d.BitCount", i), 32'(BitCount), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.Valid", i), 32'(Valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d.Overrun", i), 32'(Overrun), 32'(tbl[i].ovr));
        end
        step("clr", 1'b0, 1'b0, 1'b1, 1'b0);

        // First word with back-pressure, then a dropped word.
        send_word("a5c3", 16'hA5C3, 0, 1'b0);
        chk("a5c3.Q", 32'(Q), 32'hA5C3);
        chk("a5c3.Valid", 32'(Valid), 32'h1);
        chk("a5c3.BitCount", 32'(BitCount), 32'h0);
        chk("a5c3.Overrun", 32'(Overrun), 32'h0);
        send_word("drop", 16'h1234, 0, 1'b0);
        chk("drop.Q", 32'(Q), 32'hA5C3);
        chk("drop.Overrun", 32'(Overrun), 32'h1);
        step("consume", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("consume.Valid", 32'(Valid), 32'h0);
        chk("consume.Overrun", 32'(Overrun), 32'h1);
        step("start", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("start.Overrun", 32'(Overrun), 32'h0);

        // Strobes every other cycle.
        send_word("8001", 16'h8001, 1, 1'b0);
        chk("8001.Q", 32'(Q), 32'h8001);
        chk("8001.Valid", 32'(Valid), 32'h1);
        step("consume2", 1'b0, 1'b0, 1'b0, 1'b1);

        // Consume and refill on the same edge.
        send_word("00ff", 16'h00FF, 0, 1'b0);
        send_word("ff00", 16'hFF00, 0, 1'b1);
        chk("ff00.Q", 32'(Q), 32'hFF00);
        chk("ff00.Valid", 32'(Valid), 32'h1);
        chk("ff00.Overrun", 32'(Overrun), 32'h0);
        step("consume3", 1'b0, 1'b0, 1'b0, 1'b1);

        // Start mid-word discards the partial word and the coincident bit.
        for (int i = 0; i < 7; i++) step("part", 1'b1, 1'(i & 1), 1'b0, 1'b0);
        chk("part.BitCount", 32'(BitCount), 32'd7);
        step("restart", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("restart.BitCount", 32'(BitCount), 32'h0);
        send_word("5a5a", 16'h5A5A, 0, 1'b0);
        chk("5a5a.Q", 32'(Q), 32'h5A5A);

        // Async reset between edges with a partial word and a full buffer.
        for (int i = 0; i < 9; i++) step("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst.BitCount", 32'(BitCount), 32'd9);
        chk("pre_rst.Valid", 32'(Valid), 32'h1);
        #2 Reset = 1'b1;
        #1;
        chk("arst.Q", 32'(Q), 32'h0);
        chk("arst.Valid", 32'(Valid), 32'h0);
        chk("arst.BitCount", 32'(BitCount), 32'h0);
        chk("arst.Overrun", 32'(Overrun), 32'h0);
        Enable = 1'b1;
        @(posedge Clock);
        #1;
        chk("arst_hold.BitCount", 32'(BitCount), 32'h0);
        #2 Reset = 1'b0;
        model_reset();
        send_word("c0de", 16'hC0DE, 0, 1'b0);
        chk("c0de.Q", 32'(Q), 32'hC0DE);
        chk("c0de.Valid", 32'(Valid), 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), 1'($urandom()),
                 ($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
